io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// ============================================================================
// Module   : io_bus_arbiter
// Brief    : Two-master round-robin arbiter with bounded lock onto one IO bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_we,
  output logic          bus_rd_en,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;

  localparam int c_cnt_w = $clog2(LOCK_MAX) + 1;
  // Counter holds consecutive locked re-grants, so the first grant of a run is
  // not counted and the holder may be re-granted at most LOCK_MAX-1 times.
  localparam logic [c_cnt_w-1:0] c_lock_lim = c_cnt_w'(LOCK_MAX - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_last_grant;
  logic [c_cnt_w-1:0] r_lock_cnt;
  logic               r_we;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic [DW-1:0]      r_m0_rdata;
  logic [DW-1:0]      r_m1_rdata;
  logic               w_any_req;
  logic               w_hold;
  logic               w_win;
  logic               w_win_lock;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_any_req   = m0_req | m1_req;
    w_hold      = (r_last_grant ? m1_lock : m0_lock) && (r_lock_cnt < c_lock_lim);
    if (m0_req && m1_req) w_win = w_hold ? r_last_grant : ~r_last_grant;
    else                  w_win = m1_req;
    w_win_lock  = w_win ? m1_lock : m0_lock;
    case (r_state)
      c_st_idle:   if (w_any_req) w_state_nxt = c_st_access;
      c_st_access: w_state_nxt = c_st_resp;
      c_st_resp:   w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_lock_cnt   <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      if (r_state == c_st_idle && w_any_req) begin
        r_last_grant <= w_win;
        r_we         <= w_win ? m1_we    : m0_we;
        r_addr       <= w_win ? m1_addr  : m0_addr;
        r_wdata      <= w_win ? m1_wdata : m0_wdata;
        if (w_win != r_last_grant || !w_win_lock) r_lock_cnt <= '0;
        else if (r_lock_cnt < c_lock_lim)         r_lock_cnt <= r_lock_cnt + 1'b1;
      end
      // Read data is sampled on the edge leaving ACCESS and held until the
      // same master's next transaction overwrites it.
      if (r_state == c_st_access) begin
        if (r_last_grant) r_m1_rdata <= r_we ? '0 : bus_rdata;
        else              r_m0_rdata <= r_we ? '0 : bus_rdata;
      end
    end
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    bus_we    = 1'b0;
    bus_rd_en = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    busy      = (r_state != c_st_idle);
    m0_rdata  = r_m0_rdata;
    m1_rdata  = r_m1_rdata;
    case (r_state)
      c_st_access: begin
        m0_gnt    = ~r_last_grant;
        m1_gnt    = r_last_grant;
        bus_we    = r_we;
        bus_rd_en = ~r_we;
        bus_addr  = r_addr;
        bus_wdata = r_wdata;
      end
      c_st_resp: begin
        m0_gnt = ~r_last_grant;
        m1_gnt = r_last_grant;
        m0_ack = ~r_last_grant;
        m1_ack = r_last_grant;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
// ============================================================================
// Module   : tb_io_bus_arbiter
// Brief    : Scoreboard bench for io_bus_arbiter: order, latency, data, reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_bus_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_we, bus_rd_en, busy;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  typedef struct packed {
    logic          mst;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   ack_log[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   strobe_cyc = -10;

  io_bus_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_we(bus_we), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Peripheral model: read data only valid while the read strobe is up.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    return {a[15:0], 16'hC0DE};
  endfunction

  always_comb bus_rdata = bus_rd_en ? rd_model(bus_addr) : '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic mst, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.mst = mst; t.we = we; t.addr = a; t.wdata = d;
    t.rdata = we ? '0 : rd_model(a);
    sb.push_back(t);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    int c = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (m0_ack | m1_ack) got++;
    end
    if (got < n) check_eq("ack_timeout", 64'(got), 64'(n));
  endtask

  task automatic check_reset_state();
    check_eq("rst_ctrl", {57'b0, m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, bus_rd_en, busy}, 64'd0);
    check_eq("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    check_eq("rst_bus", {bus_addr, bus_wdata}, 64'd0);
  endtask

  // Monitor: scoreboard pop on ack, bus content on strobe, quiet bus otherwise.
  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (!reset) begin
      if (busy) check_eq("gnt_onehot", 64'(m0_gnt ^ m1_gnt), 64'd1);
      else check_eq("idle_ctrl", {58'b0, m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, bus_rd_en}, 64'd0);
      if (bus_we | bus_rd_en) begin
        if (sb.size() == 0) check_eq("strobe_unexpected", 64'd1, 64'd0);
        else begin
          t = sb[0];
          check_eq("strobe_master", 64'(m1_gnt), 64'(t.mst));
          check_eq("strobe_dir", {62'b0, bus_we, bus_rd_en}, {62'b0, t.we, ~t.we});
          check_eq("bus_addr", 64'(bus_addr), 64'(t.addr));
          if (t.we) check_eq("bus_wdata", 64'(bus_wdata), 64'(t.wdata));
          strobe_cyc = cyc;
        end
      end else begin
        check_eq("bus_quiet", {bus_addr, bus_wdata}, 64'd0);
      end
      if (m0_ack | m1_ack) begin
        if (sb.size() == 0) check_eq("ack_unexpected", 64'd1, 64'd0);
        else begin
          t = sb.pop_front();
          check_eq("ack_master", {62'b0, m0_ack, m1_ack}, {62'b0, ~t.mst, t.mst});
          check_eq("ack_latency", 64'(cyc - strobe_cyc), 64'd1);
          check_eq("rdata", 64'(t.mst ? m1_rdata : m0_rdata), 64'(t.rdata));
          ack_log.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    // Single write from m0 with exact cycle positions.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0104; m0_wdata = 32'h0000_00A5;
    push(1'b0, 1'b1, 32'h0000_0104, 32'h0000_00A5);
    @(negedge clk);
    m0_req = 1'b0; m0_addr = '1; m0_wdata = '1;
    check_eq("wr_strobe_n1", {62'b0, bus_we, m0_gnt}, 64'd3);
    @(negedge clk);
    check_eq("wr_ack_n2", {61'b0, m0_ack, bus_we, busy}, 64'd5);
    check_eq("wr_rdata_zero", 64'(m0_rdata), 64'd0);
    @(negedge clk);
    check_eq("wr_done", {62'b0, busy, m0_ack}, 64'd0);

    // Single read from m1, request dropped while in ACCESS.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    push(1'b1, 1'b0, 32'h0000_0200, '0);
    @(negedge clk);
    m1_req = 1'b0;
    check_eq("rd_strobe_n1", {62'b0, bus_rd_en, m1_gnt}, 64'd3);
    @(negedge clk);
    check_eq("rd_ack_n2", {62'b0, m1_ack, m0_gnt}, 64'd2);
    check_eq("rd_data", 64'(m1_rdata), 64'hDEAD_BEEF);
    @(negedge clk);
    check_eq("rd_single_ack", {62'b0, m1_ack, busy}, 64'd0);

    // Another m0 write must leave m1's read data untouched.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0108; m0_wdata = 32'h0000_005A;
    push(1'b0, 1'b1, 32'h0000_0108, 32'h0000_005A);
    wait_acks(1, 10);
    m0_req = 1'b0;
    check_eq("rdata_hold", 64'(m1_rdata), 64'hDEAD_BEEF);

    // Tie after reset: m0 first, strictly alternating, acks 3 cycles apart.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0300;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0400; m1_wdata = 32'h0000_1111;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 32'h0000_0300, '0);
      push(1'b1, 1'b1, 32'h0000_0400, 32'h0000_1111);
    end
    wait_acks(4, 40);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    n = ack_log.size();
    if (n >= 4) begin
      for (int i = n - 3; i < n; i++) check_eq("tie_gap", 64'(ack_log[i] - ack_log[i-1]), 64'd3);
    end else check_eq("tie_ack_count", 64'(n), 64'd4);

    // Lock limit: locked m0 gets LOCK_MAX grants, then m1 is served.
    repeat (2) @(negedge clk);
    m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0500;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0800; m1_wdata = 32'h0000_2222;
    for (int i = 0; i < LOCK_MAX; i++) push(1'b0, 1'b0, 32'h0000_0500, '0);
    push(1'b1, 1'b1, 32'h0000_0800, 32'h0000_2222);
    wait_acks(LOCK_MAX + 1, 60);
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS aborts without ack and clears everything.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0900; m0_wdata = 32'h0000_0033;
    push(1'b0, 1'b1, 32'h0000_0900, 32'h0000_0033);
    @(negedge clk);
    m0_req = 1'b0;
    check_eq("abort_in_access", 64'(bus_we), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_no_ack", {61'b0, m0_ack, m1_ack, busy}, 64'd0);

    // Tie right after that reset goes to m0 first.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0600; m0_wdata = 32'h0000_0077;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0700;
    push(1'b0, 1'b1, 32'h0000_0600, 32'h0000_0077);
    push(1'b1, 1'b0, 32'h0000_0700, '0);
    wait_acks(2, 20);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
